// File: rtl/pwm_ctrl_pkg.sv
// rtl/pwm_ctrl_pkg.sv - shared constants and state encoding for the PWM fade sequencer
// Holds the register map addresses, CTRL bit positions and FSM state type.
package pwm_ctrl_pkg;

   localparam logic [2:0] ADDR_CTRL     = 3'd0;
   localparam logic [2:0] ADDR_LEVEL_LO = 3'd1;
   localparam logic [2:0] ADDR_LEVEL_HI = 3'd2;
   localparam logic [2:0] ADDR_STEP     = 3'd3;
   localparam logic [2:0] ADDR_INTERVAL = 3'd4;
   localparam logic [2:0] ADDR_DUTY     = 3'd5;

   localparam int CTRL_START  = 0;
   localparam int CTRL_STOP   = 1;
   localparam int CTRL_BOUNCE = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2
   } fade_state_t;

endpackage

// File: rtl/pwm_tick_gen.sv
// rtl/pwm_tick_gen.sv - base tick prescaler for the fade sequencer
// Ports:
//   clk   - system clock
//   rst   - synchronous active-high reset
//   clear - restart the prescaler from zero (wins over run)
//   run   - count only while asserted
//   tick  - one-cycle pulse every TICK_DIV running cycles
module pwm_tick_gen #(
   parameter int TICK_DIV = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt_q <= '0;
      end else if (run) begin
         if (cnt_q == LAST) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   // Tick sits on the last count so the first one arrives TICK_DIV cycles after a clear.
   assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/pwm_fade_controller.sv
// rtl/pwm_fade_controller.sv - autonomous linear fade sequencer feeding pwm_peripheral duty
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   cfg_wr          - one-cycle write strobe from the SPI register file
//   cfg_addr        - register select
//   cfg_data        - write data
//   pwm_duty_cycle  - registered duty value
//   busy            - high while a fade runs
//   done            - one-cycle pulse when a single-shot fade lands on HI
module pwm_fade_controller
   import pwm_ctrl_pkg::*;
#(
   parameter int DUTY_W   = 8,
   parameter int TICK_DIV = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_wr,
   input  logic [2:0]        cfg_addr,
   input  logic [DUTY_W-1:0] cfg_data,
   output logic [DUTY_W-1:0] pwm_duty_cycle,
   output logic              busy,
   output logic              done
);

   localparam logic [DUTY_W-1:0] ONE = DUTY_W'(1);

   fade_state_t       state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic              done_q, done_d;
   logic [DUTY_W-1:0] lo_q, hi_q, step_q, interval_q;
   logic              bounce_q;
   logic [DUTY_W-1:0] icnt_q;

   logic              tick;
   logic              run;
   logic              start_evt;
   logic              cnt_clear;
   logic              step_evt;

   logic [DUTY_W-1:0] step_eff, interval_eff;
   logic [DUTY_W:0]   icnt_inc;
   logic [DUTY_W:0]   up_sum;
   logic [DUTY_W:0]   dn_floor;
   logic              up_hit, dn_hit;

   assign run = (state_q != ST_IDLE);

   pwm_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst   (rst),
      .clear (cnt_clear),
      .run   (run),
      .tick  (tick)
   );

   // Zero step or interval would stall the fade, so both behave as one.
   assign step_eff     = (step_q == '0) ? ONE : step_q;
   assign interval_eff = (interval_q == '0) ? ONE : interval_q;

   // Greater-or-equal keeps working if INTERVAL is lowered below the running count.
   assign icnt_inc = {1'b0, icnt_q} + {{DUTY_W{1'b0}}, 1'b1};
   assign step_evt = tick && (icnt_inc >= {1'b0, interval_eff});

   // One extra bit so the add never wraps; also clamps when duty already exceeds a lowered HI.
   assign up_sum   = {1'b0, duty_q} + {1'b0, step_eff};
   assign up_hit   = (up_sum >= {1'b0, hi_q});
   // Compare against LO+STEP instead of subtracting so the result never underflows.
   assign dn_floor = {1'b0, lo_q} + {1'b0, step_eff};
   assign dn_hit   = ({1'b0, duty_q} <= dn_floor);

   always_comb begin
      state_d   = state_q;
      duty_d    = duty_q;
      done_d    = 1'b0;
      start_evt = 1'b0;

      if (step_evt) begin
         case (state_q)
            ST_UP: begin
               if (up_hit) begin
                  duty_d = hi_q;
                  if (bounce_q) begin
                     state_d = ST_DOWN;
                  end else begin
                     state_d = ST_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  duty_d = up_sum[DUTY_W-1:0];
               end
            end
            ST_DOWN: begin
               if (dn_hit) begin
                  duty_d  = lo_q;
                  state_d = ST_UP;
               end else begin
                  duty_d = duty_q - step_eff;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end

      // Register writes override whatever the step logic decided this cycle.
      if (cfg_wr) begin
         if (cfg_addr == ADDR_CTRL) begin
            if (cfg_data[CTRL_STOP]) begin
               state_d = ST_IDLE;
               duty_d  = duty_q;
               done_d  = 1'b0;
            end else if (cfg_data[CTRL_START]) begin
               start_evt = 1'b1;
               if (lo_q >= hi_q) begin
                  duty_d  = hi_q;
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  duty_d  = lo_q;
                  state_d = ST_UP;
                  done_d  = 1'b0;
               end
            end
         end else if (cfg_addr == ADDR_DUTY) begin
            duty_d  = cfg_data;
            state_d = ST_IDLE;
            done_d  = 1'b0;
         end
      end
   end

   assign cnt_clear = start_evt || (state_d == ST_IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         duty_q     <= '0;
         done_q     <= 1'b0;
         lo_q       <= '0;
         hi_q       <= '1;
         step_q     <= ONE;
         interval_q <= ONE;
         bounce_q   <= 1'b0;
         icnt_q     <= '0;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         done_q  <= done_d;

         if (cnt_clear || step_evt) begin
            icnt_q <= '0;
         end else if (tick) begin
            icnt_q <= icnt_inc[DUTY_W-1:0];
         end

         if (cfg_wr) begin
            case (cfg_addr)
               ADDR_CTRL:     bounce_q   <= cfg_data[CTRL_BOUNCE];
               ADDR_LEVEL_LO: lo_q       <= cfg_data;
               ADDR_LEVEL_HI: hi_q       <= cfg_data;
               ADDR_STEP:     step_q     <= cfg_data;
               ADDR_INTERVAL: interval_q <= cfg_data;
               default:       ;
            endcase
         end
      end
   end

   assign pwm_duty_cycle = duty_q;
   assign busy           = (state_q != ST_IDLE);
   assign done           = done_q;

endmodule

// File: tb/tb_pwm_fade_controller.sv
// tb/tb_pwm_fade_controller.sv - self-checking bench for pwm_fade_controller
module tb_pwm_fade_controller;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_wr;
   logic [2:0] cfg_addr;
   logic [7:0] cfg_data;
   logic [7:0] pwm_duty_cycle;
   logic       busy;
   logic       done;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;
   int done_cnt  = 0;
   int exp_q[$];

   pwm_fade_controller #(
      .DUTY_W   (8),
      .TICK_DIV (TD)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .cfg_wr         (cfg_wr),
      .cfg_addr       (cfg_addr),
      .cfg_data       (cfg_data),
      .pwm_duty_cycle (pwm_duty_cycle),
      .busy           (busy),
      .done           (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done === 1'b1) done_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a falling edge; the write is captured on the next rising edge.
   task automatic wr(input logic [2:0] a, input logic [7:0] d);
      cfg_wr   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      @(negedge clk);
      cfg_wr   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Reference: the list of duty values a fade visits, one entry per step.
   function automatic void build_seq(input int lo, input int hi, input int st,
                                     input bit bounce, input int nmax);
      int s;
      int d;
      bit up;
      s  = (st == 0) ? 1 : st;
      d  = lo;
      up = 1'b1;
      exp_q.delete();
      exp_q.push_back(lo);
      while (exp_q.size() < nmax) begin
         if (up) begin
            d = (d + s > hi) ? hi : d + s;
            exp_q.push_back(d);
            if (d == hi) begin
               if (!bounce) break;
               up = 1'b0;
            end
         end else begin
            d = (d - s < lo) ? lo : d - s;
            exp_q.push_back(d);
            if (d == lo) up = 1'b1;
         end
      end
   endfunction

   // Walk the expected list right after START: value must hold for per-1 cycles then step.
   task automatic follow(input string tag, input int per, input bit single);
      bit last;
      check({tag, " start duty"}, pwm_duty_cycle, exp_q[0]);
      check({tag, " start busy"}, busy, 1);
      for (int i = 1; i < exp_q.size(); i++) begin
         repeat (per - 1) @(negedge clk);
         check({tag, " hold"}, pwm_duty_cycle, exp_q[i-1]);
         @(negedge clk);
         last = single && (i == exp_q.size() - 1);
         check({tag, " step"}, pwm_duty_cycle, exp_q[i]);
         check({tag, " done"}, done, last);
         check({tag, " busy"}, busy, !last);
      end
   endtask

   initial begin
      int base;
      int lo, hi, st, iv, per;
      bit bnc;

      rst      = 1'b1;
      cfg_wr   = 1'b0;
      cfg_addr = 3'd0;
      cfg_data = 8'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      check("reset duty", pwm_duty_cycle, 0);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      base = done_cnt;
      idle(1000);
      check("idle duty", pwm_duty_cycle, 0);
      check("idle busy", busy, 0);
      check("idle done count", done_cnt - base, 0);

      // Single-shot fade 10 -> 20, step 4, 2 ticks per step.
      wr(3'd1, 8'd10);
      wr(3'd2, 8'd20);
      wr(3'd3, 8'd4);
      wr(3'd4, 8'd2);
      base = done_cnt;
      wr(3'd0, 8'h01);
      build_seq(10, 20, 4, 1'b0, 1000);
      follow("fade", 2 * TD, 1'b1);
      @(negedge clk);
      check("fade done width", done, 0);
      check("fade done count", done_cnt - base, 1);
      idle(20);
      check("fade final duty", pwm_duty_cycle, 20);

      // Bounce, then STOP.
      base = done_cnt;
      wr(3'd0, 8'h05);
      build_seq(10, 20, 4, 1'b1, 9);
      follow("bounce", 2 * TD, 1'b0);
      check("bounce done count", done_cnt - base, 0);
      wr(3'd0, 8'h02);
      check("stop busy", busy, 0);
      check("stop duty", pwm_duty_cycle, exp_q[8]);
      idle(30);
      check("stop frozen", pwm_duty_cycle, exp_q[8]);

      // HI lowered below current duty mid-fade: next step clamps.
      wr(3'd1, 8'd0);
      wr(3'd2, 8'd200);
      wr(3'd3, 8'd10);
      wr(3'd4, 8'd1);
      wr(3'd0, 8'h01);
      build_seq(0, 200, 10, 1'b0, 4);
      follow("hichg", TD, 1'b0);
      wr(3'd2, 8'd25);
      idle(TD - 2);
      check("hichg hold", pwm_duty_cycle, 30);
      @(negedge clk);
      check("hichg clamp", pwm_duty_cycle, 25);
      check("hichg done", done, 1);
      check("hichg busy", busy, 0);

      // LO >= HI: immediate landing on HI.
      wr(3'd1, 8'd200);
      wr(3'd2, 8'd100);
      wr(3'd0, 8'h01);
      check("inv duty", pwm_duty_cycle, 100);
      check("inv done", done, 1);
      check("inv busy", busy, 0);

      // Direct override aborts a fade.
      wr(3'd1, 8'd10);
      wr(3'd2, 8'd200);
      wr(3'd3, 8'd1);
      wr(3'd4, 8'd1);
      wr(3'd0, 8'h01);
      build_seq(10, 200, 1, 1'b0, 4);
      follow("ovr", TD, 1'b0);
      wr(3'd5, 8'h55);
      check("ovr duty", pwm_duty_cycle, 8'h55);
      check("ovr busy", busy, 0);
      check("ovr done", done, 0);
      idle(40);
      check("ovr frozen", pwm_duty_cycle, 8'h55);

      // STEP=0 and INTERVAL=0 act as 1.
      wr(3'd1, 8'd0);
      wr(3'd2, 8'd5);
      wr(3'd3, 8'd0);
      wr(3'd4, 8'd0);
      wr(3'd0, 8'h01);
      build_seq(0, 5, 0, 1'b0, 1000);
      follow("zero", TD, 1'b1);

      // START and STOP together: STOP wins.
      wr(3'd1, 8'd10);
      wr(3'd2, 8'd200);
      wr(3'd3, 8'd3);
      wr(3'd4, 8'd1);
      wr(3'd0, 8'h01);
      build_seq(10, 200, 3, 1'b0, 3);
      follow("ss", TD, 1'b0);
      wr(3'd0, 8'h03);
      check("ss busy", busy, 0);
      check("ss duty", pwm_duty_cycle, 16);
      idle(20);
      check("ss frozen", pwm_duty_cycle, 16);

      // Reset mid-fade with a simultaneous START write.
      wr(3'd1, 8'd50);
      wr(3'd2, 8'd250);
      wr(3'd3, 8'd7);
      wr(3'd0, 8'h05);
      idle(9);
      rst      = 1'b1;
      cfg_wr   = 1'b1;
      cfg_addr = 3'd0;
      cfg_data = 8'h01;
      @(negedge clk);
      check("rst duty", pwm_duty_cycle, 0);
      check("rst busy", busy, 0);
      check("rst done", done, 0);
      rst    = 1'b0;
      cfg_wr = 1'b0;
      @(negedge clk);
      // Registers back at defaults: LO=0, HI=255, STEP=1, INTERVAL=1.
      wr(3'd0, 8'h01);
      build_seq(0, 255, 1, 1'b0, 3);
      follow("dflt", TD, 1'b0);
      wr(3'd0, 8'h02);

      // Randomized fades.
      for (int r = 0; r < 4; r++) begin
         lo  = $urandom_range(0, 120);
         hi  = $urandom_range(lo + 1, 255);
         st  = $urandom_range(0, 40);
         iv  = $urandom_range(0, 3);
         bnc = r[0];
         per = ((iv == 0) ? 1 : iv) * TD;
         wr(3'd1, 8'(lo));
         wr(3'd2, 8'(hi));
         wr(3'd3, 8'(st));
         wr(3'd4, 8'(iv));
         base = done_cnt;
         wr(3'd0, bnc ? 8'h05 : 8'h01);
         build_seq(lo, hi, st, bnc, bnc ? 12 : 1000);
         follow("rand", per, !bnc);
         if (bnc) begin
            wr(3'd0, 8'h02);
            check("rand stop busy", busy, 0);
            check("rand bounce done count", done_cnt - base, 0);
         end else begin
            idle(3);
            check("rand done count", done_cnt - base, 1);
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
